// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the lab processor front end: the fetch FSM state
// encoding and the default field widths of an instruction word.
package proc_pkg;

    localparam int OPC_W_DEF  = 3;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
// LIFO of return addresses for the fetch unit's call/return support.
// Ports:
//   Clock, Reset   rising-edge clock, async active-low reset
//   Clear          empty the stack (synchronous)
//   Push, PushData write PushData on top (ignored when Full)
//   Pop            discard top entry (ignored when Empty)
//   TopData        current top entry (valid when !Empty)
//   Full, Empty    occupancy flags
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         Push,
    input  logic         Pop,
    input  logic [W-1:0] PushData,
    output logic [W-1:0] TopData,
    output logic         Full,
    output logic         Empty
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    // sp_q counts entries; one extra bit so DEPTH itself is representable.
    logic [SPW-1:0] sp_q;
    logic [W-1:0]   mem_q [DEPTH];

    assign Full    = (sp_q == SPW'(DEPTH));
    assign Empty   = (sp_q == '0);
    assign TopData = mem_q[AW'(sp_q - 1'b1)];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (Clear) begin
            sp_q <= '0;
        end else if (Push && !Full) begin
            mem_q[sp_q[AW-1:0]] <= PushData;
            sp_q                <= sp_q + 1'b1;
        end else if (Pop && !Empty) begin
            sp_q <= sp_q - 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction fetch / program counter unit: owns IR, PC and the memory
// address mux, sequencing IDLE -> FETCH -> EXEC with a memory ready
// handshake, conditional jump and an optional call/return stack.
// Optional feature macro: FETCH_CALL_STACK_EN (builds the return stack;
// without it Call/Ret act as sequential and StackErr stays 0).
// Ports:
//   Clock, Reset          clock, async active-low reset
//   Start                 leave IDLE, reload PC, clear stack and StackErr
//   MemRdata, MemRdy      memory read data and its valid strobe
//   ExecDone              execute controller finished the instruction
//   Jump, Cond            conditional jump to Operand
//   Call, Ret             subroutine call to Operand / return
//   Halt                  go to IDLE after this instruction
//   DataAccess            in EXEC, MemAddr follows Operand
//   MemAddr, MemRd        memory address and fetch request
//   Opcode, Operand       IR fields, valid while InstrValid
//   PC, StackErr          program counter, sticky stack error
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int OPC_W       = OPC_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [OPC_W+ADDR_W-1:0]   MemRdata,
    input  logic                      MemRdy,
    input  logic                      ExecDone,
    input  logic                      Jump,
    input  logic                      Cond,
    input  logic                      Call,
    input  logic                      Ret,
    input  logic                      Halt,
    input  logic                      DataAccess,
    output logic [ADDR_W-1:0]         MemAddr,
    output logic                      MemRd,
    output logic [OPC_W-1:0]          Opcode,
    output logic [ADDR_W-1:0]         Operand,
    output logic                      InstrValid,
    output logic [ADDR_W-1:0]         PC,
    output logic                      StackErr
);
    localparam int                INSTR_W = OPC_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic                mem_rd_q;
    logic                ivalid_q;
    logic                stk_err_q;

    logic                ret_req, call_req;
    logic                stk_full, stk_empty;
    logic [ADDR_W-1:0]   stk_top;
    logic                exec_done;

    assign exec_done = (state_q == ST_EXEC) && ExecDone;

`ifdef FETCH_CALL_STACK_EN
    logic stk_push, stk_pop, stk_clear;

    assign ret_req   = Ret;
    assign call_req  = Call;
    // Ret outranks Call, so push and pop are mutually exclusive.
    assign stk_pop   = exec_done && Ret && !stk_empty;
    assign stk_push  = exec_done && !Ret && Call && !stk_full;
    assign stk_clear = (state_q == ST_IDLE) && Start;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .Clock    (Clock),
        .Reset    (Reset),
        .Clear    (stk_clear),
        .Push     (stk_push),
        .Pop      (stk_pop),
        .PushData (pc_q),      // already points past the call
        .TopData  (stk_top),
        .Full     (stk_full),
        .Empty    (stk_empty)
    );
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    logic unused_call_ret;

    assign unused_call_ret = Call ^ Ret;
    assign ret_req   = 1'b0;
    assign call_req  = 1'b0;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_top   = '0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_RST;
            ir_q      <= '0;
            mem_rd_q  <= 1'b0;
            ivalid_q  <= 1'b0;
            stk_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_q   <= ST_FETCH;
                        pc_q      <= PC_RST;
                        stk_err_q <= 1'b0;
                        mem_rd_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (MemRdy) begin
                        state_q  <= ST_EXEC;
                        ir_q     <= MemRdata;
                        pc_q     <= pc_q + 1'b1;  // wraps mod 2^ADDR_W
                        mem_rd_q <= 1'b0;
                        ivalid_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (ExecDone) begin
                        if (ret_req) begin
                            if (!stk_empty) pc_q <= stk_top;
                            else            stk_err_q <= 1'b1;
                        end else if (call_req) begin
                            if (!stk_full)  pc_q <= ir_q[ADDR_W-1:0];
                            else            stk_err_q <= 1'b1;
                        end else if (Jump && Cond) begin
                            pc_q <= ir_q[ADDR_W-1:0];
                        end
                        ivalid_q <= 1'b0;
                        state_q  <= Halt ? ST_IDLE : ST_FETCH;
                        mem_rd_q <= !Halt;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_rd_q <= 1'b0;
                    ivalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Opcode     = ir_q[INSTR_W-1:ADDR_W];
    assign Operand    = ir_q[ADDR_W-1:0];
    assign PC         = pc_q;
    assign MemRd      = mem_rd_q;
    assign InstrValid = ivalid_q;
    // Stack error register is never set when the stack is not built.
    assign StackErr   = stk_err_q;
    assign MemAddr    = (state_q == ST_EXEC && DataAccess) ? ir_q[ADDR_W-1:0] : pc_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction-fetch and program-counter unit for the lab processor. It owns the instruction register (IR), the program counter (PC) and the memory address mux, and sequences fetch and execute with a small FSM and a memory ready handshake. It adds conditional jump and an optional call/return stack. It sits between unified program/data memory and the execute controller, which consumes `Opcode`/`Operand` and reports completion.

## Interface
Parameters:
- `OPC_W`, 3, opcode width (IR upper field)
- `ADDR_W`, 5, address/operand width (IR lower field, PC width)
- `RESET_PC`, 0, PC value after reset and on `Start`
- `STACK_DEPTH`, 4, call-stack entries (power of two, ≥2)

Ports (instruction width INSTR_W = OPC_W+ADDR_W):
- `Clock`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  leave IDLE; reload PC with RESET_PC, clear StackErr and stack
- `MemRdata`  in  INSTR_W  memory read data
- `MemRdy`  in  1  `MemRdata` valid this cycle
- `ExecDone`  in  1  execute controller finished current instruction
- `Jump`  in  1  jump request, qualified by `ExecDone`
- `Cond`  in  1  branch condition; jump taken only if `Cond`=1
- `Call`, `Ret`  in  1  call/return request, qualified by `ExecDone`
- `Halt`  in  1  return to IDLE after this instruction
- `DataAccess`  in  1  in EXEC, drive `MemAddr` from `Operand`
- `MemAddr`  out  ADDR_W  memory address
- `MemRd`  out  1  fetch request
- `Opcode`  out  OPC_W  IR[INSTR_W-1:ADDR_W]
- `Operand`  out  ADDR_W  IR[ADDR_W-1:0]
- `InstrValid`  out  1  IR holds an instruction under execution
- `PC`  out  ADDR_W  current PC
- `StackErr`  out  1  sticky stack overflow/underflow

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: `MemRd`=0, `InstrValid`=0. `Start` → PC←RESET_PC, stack empty, StackErr←0, → FETCH.
- FETCH: `MemRd`=1, `MemAddr`=PC. Edge with `MemRdy`=1: IR←MemRdata, PC←PC+1 (mod 2^ADDR_W, wraps), → EXEC. Without `MemRdy`, hold.
- EXEC: `InstrValid`=1. `MemAddr`=Operand if `DataAccess` else PC; `MemRd`=0. Edge with `ExecDone`=1 updates PC by priority:
  1. `Ret`: stack non-empty → PC←pop; empty → PC unchanged, StackErr←1.
  2. `Call`: stack not full → push PC (return address, already incremented), PC←Operand; full → PC unchanged, no push, StackErr←1.
  3. `Jump` and `Cond` → PC←Operand; `Jump` and !`Cond` → PC unchanged.
  4. Otherwise PC unchanged (sequential).
  Next state: IDLE if `Halt`, else FETCH. The PC update still happens when `Halt`=1.
- `Start` is ignored outside IDLE. `Jump`/`Call`/`Ret`/`Halt` are ignored without `ExecDone`.
- `Opcode`/`Operand` are valid only while `InstrValid`=1. IR otherwise holds its last value.

## Timing
- Reset (async, `Reset`=0): state IDLE, PC=RESET_PC, IR=0, stack pointer 0, StackErr=0, MemRd=0, InstrValid=0, MemAddr=RESET_PC.
- All outputs are derived from registers or from the registered state plus `DataAccess`. There are no other combinational input-to-output paths.
- Minimum of 2 cycles per instruction: FETCH with `MemRdy` in the same cycle, then EXEC with `ExecDone` in its first cycle.
- A reset asserted mid-FETCH or mid-EXEC aborts immediately. No partial IR or stack update survives.
- Push and pop never occur in the same cycle, because the priority order above excludes it.

## Configuration
- `FETCH_CALL_STACK_EN` defined: the call stack is built, and `Call`/`Ret`/`StackErr` behave as above.
- Undefined: no stack storage. `Call` and `Ret` are treated as sequential. `StackErr` is tied to 0. `STACK_DEPTH` is unused.

## Structure
- Shared package `proc_pkg`: FSM state encoding (IDLE/FETCH/EXEC) and default widths (OPC_W, ADDR_W).
- One sub-module, `ret_stack`: a LIFO of depth STACK_DEPTH × ADDR_W with push, pop, full and empty. It is instantiated only under `FETCH_CALL_STACK_EN`.
- IR, PC, the incrementer and the address mux stay inline.

## Test plan
- Reset, then `Start`, with memory returning `MemRdy` immediately, 8-bit word 0x6A → Opcode=3, Operand=0x0A, PC=1, InstrValid=1 one cycle after FETCH.
- `MemRdy` delayed 3 cycles → MemRd held at 1 and MemAddr=PC throughout; IR loads only on the `MemRdy` edge.
- EXEC with Operand=0x15: `Jump`+`Cond`=1 → next fetch at 0x15. `Jump`+`Cond`=0 → next fetch at PC+1.
- PC=0x1F, sequential fetch → PC wraps to 0x00.
- With `FETCH_CALL_STACK_EN`: 4 nested `Call`s succeed. The 5th sets StackErr, and PC continues sequentially. Then 4 `Ret`s return in reverse order, and a 5th `Ret` keeps StackErr=1.
- `Reset` pulsed low mid-EXEC → all outputs return to reset values asynchronously. `Halt` with `ExecDone` → IDLE, MemRd=0.
